// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data load-store) arbiter onto one word-wide memory port.
// Round-robin on contention, registered memory request, watchdog abort on a missing mack.
module mem_arbiter #(
  parameter int AW      = 30,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iadr,
  output logic [31:0]   irdata,
  output logic          iack,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] dadr,
  input  logic [31:0]   dwdata,
  input  logic [3:0]    dbyteen,
  output logic [31:0]   drdata,
  output logic          dack,
  output logic          buserr,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] madr,
  output logic [31:0]   mwdata,
  output logic [3:0]    mbyteen,
  input  logic [31:0]   mrdata,
  input  logic          mack
);

  // The watchdog only has to count up to TIMEOUT-1; reaching that value with no mack aborts.
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state, state_nxt;
  logic          gnt_data, gnt_data_nxt;
  logic          last_data, last_data_nxt;
  logic [WW-1:0] wd, wd_nxt;
  logic          pick_data;
  logic          expire;

  logic          mreq_nxt, mwe_nxt, iack_nxt, dack_nxt, buserr_nxt;
  logic [AW-1:0] madr_nxt;
  logic [31:0]   mwdata_nxt, irdata_nxt, drdata_nxt;
  logic [3:0]    mbyteen_nxt;

  // Data wins when it is the only requester or when instruction had the last grant.
  assign pick_data = dreq && (!ireq || !last_data);
  assign expire    = (wd == WD_LAST) && !mack;

  // State and every output are registered; reset parks the arbiter with instruction as last grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt_data  <= 1'b0;
      last_data <= 1'b0;
      wd        <= '0;
      mreq      <= 1'b0;
      mwe       <= 1'b0;
      madr      <= '0;
      mwdata    <= 32'h0;
      mbyteen   <= 4'b0000;
      irdata    <= 32'h0;
      drdata    <= 32'h0;
      iack      <= 1'b0;
      dack      <= 1'b0;
      buserr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      gnt_data  <= gnt_data_nxt;
      last_data <= last_data_nxt;
      wd        <= wd_nxt;
      mreq      <= mreq_nxt;
      mwe       <= mwe_nxt;
      madr      <= madr_nxt;
      mwdata    <= mwdata_nxt;
      mbyteen   <= mbyteen_nxt;
      irdata    <= irdata_nxt;
      drdata    <= drdata_nxt;
      iack      <= iack_nxt;
      dack      <= dack_nxt;
      buserr    <= buserr_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ireq || dreq) state_nxt = BUSY;
        else              state_nxt = IDLE;
      end
      BUSY: begin
        if (mack || expire) state_nxt = RESP;
        else                state_nxt = BUSY;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs and bookkeeping; acks and buserr live only in RESP.
  always_comb begin
    gnt_data_nxt  = gnt_data;
    last_data_nxt = last_data;
    wd_nxt        = wd;
    mreq_nxt      = mreq;
    mwe_nxt       = mwe;
    madr_nxt      = madr;
    mwdata_nxt    = mwdata;
    mbyteen_nxt   = mbyteen;
    irdata_nxt    = irdata;
    drdata_nxt    = drdata;
    iack_nxt      = 1'b0;
    dack_nxt      = 1'b0;
    buserr_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (ireq || dreq) begin
          mreq_nxt      = 1'b1;
          gnt_data_nxt  = pick_data;
          last_data_nxt = pick_data;
          wd_nxt        = '0;
          if (pick_data) begin
            mwe_nxt     = dwe;
            madr_nxt    = dadr;
            mwdata_nxt  = dwdata;
            mbyteen_nxt = dbyteen;
          end else begin
            mwe_nxt     = 1'b0;
            madr_nxt    = iadr;
            mwdata_nxt  = 32'h0;
            mbyteen_nxt = 4'b0000;
          end
        end else begin
          mreq_nxt = 1'b0;
        end
      end
      BUSY: begin
        if (mack) begin
          mreq_nxt = 1'b0;
          if (gnt_data) drdata_nxt = mrdata;
          else          irdata_nxt = mrdata;
          dack_nxt = gnt_data;
          iack_nxt = !gnt_data;
        end else if (expire) begin
          mreq_nxt   = 1'b0;
          buserr_nxt = 1'b1;
          if (gnt_data) drdata_nxt = 32'h0;
          else          irdata_nxt = 32'h0;
          dack_nxt = gnt_data;
          iack_nxt = !gnt_data;
        end else begin
          wd_nxt = wd + WW'(1);
        end
      end
      RESP: begin
        wd_nxt = '0;
      end
      default: begin
        wd_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected acks checked by a monitor,
// plus inline checks of the memory-side handshake. A second instance runs with TIMEOUT=4.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq, dreq, dwe, mack;
  logic [29:0] iadr, dadr;
  logic [31:0] dwdata, mrdata_drv, mrdata;
  logic [3:0]  dbyteen;
  logic        use_adr_data;
  logic        sel2;

  logic [31:0] irdata1, drdata1, mwdata1, irdata2, drdata2, mwdata2;
  logic        iack1, dack1, buserr1, mreq1, mwe1, iack2, dack2, buserr2, mreq2, mwe2;
  logic [29:0] madr1, madr2;
  logic [3:0]  mbyteen1, mbyteen2;

  int n_assert = 0;
  int n_fail   = 0;
  int n_iack   = 0;
  int n_dack   = 0;

  typedef struct {
    logic        is_data;
    logic [31:0] rdata;
    logic        berr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory model: either driven data or a value derived from the address being served.
  assign mrdata = use_adr_data ? {2'b10, (sel2 ? madr2 : madr1)} : mrdata_drv;

  mem_arbiter #(.AW(30), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata1), .iack(iack1),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
    .drdata(drdata1), .dack(dack1), .buserr(buserr1),
    .mreq(mreq1), .mwe(mwe1), .madr(madr1), .mwdata(mwdata1), .mbyteen(mbyteen1),
    .mrdata(mrdata), .mack(mack)
  );

  mem_arbiter #(.AW(30), .TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iadr(iadr), .irdata(irdata2), .iack(iack2),
    .dreq(dreq), .dwe(dwe), .dadr(dadr), .dwdata(dwdata), .dbyteen(dbyteen),
    .drdata(drdata2), .dack(dack2), .buserr(buserr2),
    .mreq(mreq2), .mwe(mwe2), .madr(madr2), .mwdata(mwdata2), .mbyteen(mbyteen2),
    .mrdata(mrdata), .mack(mack)
  );

  logic        m_iack, m_dack, m_buserr;
  logic [31:0] m_irdata, m_drdata;
  assign m_iack   = sel2 ? iack2 : iack1;
  assign m_dack   = sel2 ? dack2 : dack1;
  assign m_buserr = sel2 ? buserr2 : buserr1;
  assign m_irdata = sel2 ? irdata2 : irdata1;
  assign m_drdata = sel2 ? drdata2 : drdata1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push(input logic is_data, input logic [31:0] rdata, input logic berr);
    exp_t e;
    e.is_data = is_data;
    e.rdata   = rdata;
    e.berr    = berr;
    sb.push_back(e);
  endtask

  // Ack monitor: every ack pulse must match the oldest scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (m_iack || m_dack) begin
      if (m_iack) n_iack++;
      if (m_dack) n_dack++;
      if (sb.size() == 0) begin
        chk("unexpected_ack", {30'd0, m_iack, m_dack}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_sel", {30'd0, m_iack, m_dack}, e.is_data ? 32'd1 : 32'd2);
        chk("ack_rdata", e.is_data ? m_drdata : m_irdata, e.rdata);
        chk("ack_buserr", {31'd0, m_buserr}, {31'd0, e.berr});
      end
    end
  end

  initial begin
    reset = 1'b1; sel2 = 1'b0; use_adr_data = 1'b0;
    ireq = 1'b1; iadr = 30'h10; dreq = 1'b0; dwe = 1'b0; dadr = 30'h0;
    dwdata = 32'h0; dbyteen = 4'b0000; mack = 1'b0; mrdata_drv = 32'h0;

    // Reset held 3 cycles with ireq high: everything stays 0.
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_mreq", {31'd0, mreq1}, 32'd0);
      chk("rst_acks", {29'd0, iack1, dack1, buserr1}, 32'd0);
      chk("rst_madr", {2'b00, madr1}, 32'd0);
      chk("rst_rdata", irdata1 | drdata1, 32'd0);
    end
    reset = 1'b0;

    // Single instruction fetch, mack in the first BUSY cycle.
    push(1'b0, 32'h8C010004, 1'b0);
    cyc();
    chk("if_mreq", {31'd0, mreq1}, 32'd1);
    chk("if_madr", {2'b00, madr1}, 32'h10);
    chk("if_mwe", {31'd0, mwe1}, 32'd0);
    mack = 1'b1; mrdata_drv = 32'h8C010004;
    cyc();
    chk("if_mreq_drop", {31'd0, mreq1}, 32'd0);
    chk("if_iack", {31'd0, iack1}, 32'd1);
    ireq = 1'b0; mack = 1'b0;
    cyc();
    chk("if_iack_end", {31'd0, iack1}, 32'd0);

    // Store byte, mack after 4 waiting cycles.
    dreq = 1'b1; dwe = 1'b1; dadr = 30'h40; dwdata = 32'hDEADBEEF; dbyteen = 4'b0010;
    push(1'b1, 32'h12345678, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("st_mreq", {31'd0, mreq1}, 32'd1);
      chk("st_mwe", {31'd0, mwe1}, 32'd1);
      chk("st_madr", {2'b00, madr1}, 32'h40);
      chk("st_mbyteen", {28'd0, mbyteen1}, 32'h2);
      chk("st_mwdata", mwdata1, 32'hDEADBEEF);
      chk("st_no_ack", {31'd0, dack1}, 32'd0);
    end
    mack = 1'b1; mrdata_drv = 32'h12345678;
    cyc();
    chk("st_dack", {31'd0, dack1}, 32'd1);
    chk("st_mreq_drop", {31'd0, mreq1}, 32'd0);
    dreq = 1'b0; dwe = 1'b0; mack = 1'b0;
    cyc();

    // Reset so the first tie goes to data, then continuous contention.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    ireq = 1'b1; dreq = 1'b1; iadr = 30'h100; dadr = 30'h200; dbyteen = 4'b0000;
    mack = 1'b1; use_adr_data = 1'b1;
    n_iack = 0; n_dack = 0;
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 32'h80000200, 1'b0);
      push(1'b0, 32'h80000100, 1'b0);
    end
    repeat (18) cyc();
    ireq = 1'b0; dreq = 1'b0; mack = 1'b0; use_adr_data = 1'b0;
    chk("ct_sb_empty", sb.size(), 32'd0);
    chk("ct_iack_cnt", n_iack, 32'd3);
    chk("ct_dack_cnt", n_dack, 32'd3);
    cyc();

    // Timeout on the TIMEOUT=4 instance: data load, mack never comes.
    sel2 = 1'b1; mrdata_drv = 32'hFFFFFFFF;
    chk("to_pre_drdata", drdata2, 32'h80000200);
    dreq = 1'b1; dwe = 1'b0; dadr = 30'h55;
    push(1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("to_mreq", {31'd0, mreq2}, 32'd1);
    end
    cyc();
    chk("to_mreq_drop", {31'd0, mreq2}, 32'd0);
    chk("to_dack", {30'd0, dack2, buserr2}, 32'd3);
    chk("to_drdata", drdata2, 32'h0);
    dreq = 1'b0;
    cyc();
    chk("to_clear", {30'd0, dack2, buserr2}, 32'd0);

    // Reset mid-BUSY: mreq falls asynchronously, no ack, later mack ignored.
    reset = 1'b1; sel2 = 1'b0;
    cyc();
    reset = 1'b0; ireq = 1'b1; iadr = 30'h20;
    cyc();
    chk("mr_mreq_busy1", {31'd0, mreq1}, 32'd1);
    cyc();
    chk("mr_mreq_busy2", {31'd0, mreq1}, 32'd1);
    #2 reset = 1'b1;
    #1 chk("mr_mreq_async", {31'd0, mreq1}, 32'd0);
    cyc();
    reset = 1'b0; ireq = 1'b0;
    cyc();
    mack = 1'b1; mrdata_drv = 32'hCAFEF00D;
    cyc();
    mack = 1'b0;
    chk("mr_mreq_idle", {31'd0, mreq1}, 32'd0);
    cyc();
    chk("mr_no_ack", {29'd0, iack1, dack1, buserr1}, 32'd0);
    chk("mr_irdata", irdata1, 32'h0);
    chk("end_sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
